// File: rtl/chicken_race_tracker_pkg.sv
// Shared types and constants for the chicken race position/tail tracker.
// FSM state encoding plus the helper that spaces players evenly at game start.
package chicken_race_tracker_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE    = 3'd1,
    CAPTURE = 3'd2,
    CHECK   = 3'd3,
    WIN     = 3'd4
  } state_t;

  // Tiles between neighbouring players at the start of a game.
  function automatic int start_spacing(input int track_len, input int num_players);
    return track_len / num_players;
  endfunction

endpackage

// File: rtl/chicken_race_tracker_ring_adder.sv
// Combinational modulo add on the circular track: sum = (a + b) mod TRACK_LEN.
// Both operands are below TRACK_LEN, so a single conditional subtract is enough.
module chicken_race_tracker_ring_adder #(
  parameter int POS_W     = 5,
  parameter int TRACK_LEN = 24
) (
  input  logic [POS_W-1:0] a,
  input  logic [POS_W-1:0] b,
  output logic [POS_W-1:0] sum
);

  localparam logic [POS_W:0] LEN_EXT = (POS_W+1)'(TRACK_LEN);

  logic [POS_W:0] raw;
  logic [POS_W:0] wrapped;

  always_comb begin
    raw     = {1'b0, a} + {1'b0, b};
    wrapped = (raw >= LEN_EXT) ? (raw - LEN_EXT) : raw;
    sum     = wrapped[POS_W-1:0];
  end

endmodule

// File: rtl/chicken_race_tracker.sv
// Holds player positions and tail counts, runs one move per request through
// IDLE->MOVE->CAPTURE->CHECK, and latches the winner once a player owns every tail.
module chicken_race_tracker
  import chicken_race_tracker_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int TRACK_LEN   = 24,
  parameter int POS_W       = 5,
  parameter int TURN_W      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              move_req,
  input  logic                              move_hit,
  input  logic [POS_W-1:0]                  move_steps,
  input  logic                              clear_win,
  output logic                              busy,
  output logic [TURN_W-1:0]                 cur_turn,
  output logic [NUM_PLAYERS*POS_W-1:0]      pos_flat,
  output logic [NUM_PLAYERS*(TURN_W+1)-1:0] tails_flat,
  output logic [POS_W-1:0]                  afterposition_data,
  output logic                              step_err,
  output logic                              win,
  output logic [TURN_W-1:0]                 winner
);

  localparam int              SPACING = start_spacing(TRACK_LEN, NUM_PLAYERS);
  localparam logic [POS_W:0]  LEN_EXT = (POS_W+1)'(TRACK_LEN);
  localparam logic [TURN_W:0] ALL_TAILS = (TURN_W+1)'(NUM_PLAYERS);
  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(NUM_PLAYERS - 1);

  state_t            state;
  logic [POS_W-1:0]  pos   [NUM_PLAYERS];
  logic [TURN_W:0]   tails [NUM_PLAYERS];
  logic              hit_q;
  logic [POS_W-1:0]  steps_q;
  logic [POS_W-1:0]  moved_pos;
  logic [TURN_W:0]   captured;
  logic [NUM_PLAYERS-1:0] victim;

  chicken_race_tracker_ring_adder #(
    .POS_W    (POS_W),
    .TRACK_LEN(TRACK_LEN)
  ) u_ring_adder (
    .a  (pos[cur_turn]),
    .b  (steps_q),
    .sum(moved_pos)
  );

  // Everyone sharing the mover's tile is a victim, including players already at zero tails.
  always_comb begin
    captured = '0;
    victim   = '0;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (TURN_W'(j) != cur_turn && pos[j] == pos[cur_turn]) begin
        victim[j] = 1'b1;
        captured  = captured + tails[j];
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
    assign pos_flat[g*POS_W +: POS_W]             = pos[g];
    assign tails_flat[g*(TURN_W+1) +: TURN_W+1]   = tails[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      cur_turn           <= '0;
      busy               <= 1'b0;
      win                <= 1'b0;
      winner             <= '0;
      step_err           <= 1'b0;
      hit_q              <= 1'b0;
      steps_q            <= '0;
      afterposition_data <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos[i]   <= POS_W'(i * SPACING);
        tails[i] <= (TURN_W+1)'(1);
      end
    end else begin
      step_err           <= 1'b0;
      afterposition_data <= pos[cur_turn];
      case (state)
        IDLE: begin
          if (move_req) begin
            if ({1'b0, move_steps} >= LEN_EXT) begin
              step_err <= 1'b1;
            end else begin
              hit_q   <= move_hit;
              steps_q <= move_steps;
              busy    <= 1'b1;
              state   <= MOVE;
            end
          end
        end
        MOVE: begin
          if (hit_q) pos[cur_turn] <= moved_pos;
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (hit_q && steps_q != '0) begin
            for (int j = 0; j < NUM_PLAYERS; j++) begin
              if (victim[j]) tails[j] <= '0;
            end
            tails[cur_turn] <= tails[cur_turn] + captured;
          end
          state <= CHECK;
        end
        CHECK: begin
          if (tails[cur_turn] == ALL_TAILS) begin
            win    <= 1'b1;
            winner <= cur_turn;
            state  <= WIN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
            if (!hit_q) cur_turn <= (cur_turn == LAST_TURN) ? '0 : cur_turn + 1'b1;
          end
        end
        WIN: begin
          if (clear_win) begin
            state    <= IDLE;
            cur_turn <= '0;
            busy     <= 1'b0;
            win      <= 1'b0;
            winner   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              pos[i]   <= POS_W'(i * SPACING);
              tails[i] <= (TURN_W+1)'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chicken_race_tracker.sv
// Directed scenario bench for chicken_race_tracker with default parameters,
// plus a random run that checks tail conservation and position range every cycle.
module tb_chicken_race_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        move_req = 1'b0;
  logic        move_hit = 1'b0;
  logic [4:0]  move_steps = '0;
  logic        clear_win = 1'b0;
  logic        busy;
  logic [1:0]  cur_turn;
  logic [19:0] pos_flat;
  logic [11:0] tails_flat;
  logic [4:0]  afterposition_data;
  logic        step_err;
  logic        win;
  logic [1:0]  winner;

  int errors = 0;
  int checks = 0;

  chicken_race_tracker dut (
    .clk               (clk),
    .rst               (rst),
    .move_req          (move_req),
    .move_hit          (move_hit),
    .move_steps        (move_steps),
    .clear_win         (clear_win),
    .busy              (busy),
    .cur_turn          (cur_turn),
    .pos_flat          (pos_flat),
    .tails_flat        (tails_flat),
    .afterposition_data(afterposition_data),
    .step_err          (step_err),
    .win               (win),
    .winner            (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] get_pos(input int i);
    return pos_flat[i*5 +: 5];
  endfunction

  function automatic logic [2:0] get_tails(input int i);
    return tails_flat[i*3 +: 3];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    move_req = 1'b0;
    clear_win = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Leaves the bench one step past the accepting edge.
  task automatic send_move(input logic hit, input logic [4:0] steps);
    move_req   = 1'b1;
    move_hit   = hit;
    move_steps = steps;
    tick();
    move_req   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && win !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (busy === 1'b1 && win !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, busy=%0b required 0", name, busy);
    end
  endtask

  task automatic run_move(input logic hit, input logic [4:0] steps);
    send_move(hit, steps);
    wait_idle("run_move");
  endtask

  task automatic expect_reset_state(input string name);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_pos(i) !== 5'(i * 6)) begin
        errors++;
        $display("FAIL %s pos%0d: got %0d required %0d", name, i, get_pos(i), i * 6);
      end
      checks++;
      if (get_tails(i) !== 3'd1) begin
        errors++;
        $display("FAIL %s tails%0d: got %0d required 1", name, i, get_tails(i));
      end
    end
    checks++;
    if (cur_turn !== 2'd0 || win !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s ctrl: turn=%0d win=%0b busy=%0b required 0/0/0", name, cur_turn, win, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    expect_reset_state("reset");
    checks++;
    if (step_err !== 1'b0 || afterposition_data !== 5'd0 || winner !== 2'd0) begin
      errors++;
      $display("FAIL reset misc: step_err=%0b apd=%0d winner=%0d required 0/0/0",
               step_err, afterposition_data, winner);
    end
  endtask

  task automatic test_miss_then_hit();
    do_reset();
    send_move(1'b0, 5'd0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL miss busy: got %0b required 1", busy);
    end
    tick();
    tick();
    checks++;
    if (cur_turn !== 2'd0) begin
      errors++;
      $display("FAIL miss early turn: got %0d required 0", cur_turn);
    end
    tick();
    checks++;
    if (cur_turn !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL miss turn: turn=%0d busy=%0b required 1/0", cur_turn, busy);
    end
    send_move(1'b1, 5'd3);
    tick();
    checks++;
    if (get_pos(1) !== 5'd9 || afterposition_data !== 5'd6) begin
      errors++;
      $display("FAIL hit move: pos1=%0d apd=%0d required 9/6", get_pos(1), afterposition_data);
    end
    tick();
    checks++;
    if (afterposition_data !== 5'd9) begin
      errors++;
      $display("FAIL hit apd lag: got %0d required 9", afterposition_data);
    end
    tick();
    checks++;
    if (cur_turn !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hit keeps turn: turn=%0d busy=%0b required 1/0", cur_turn, busy);
    end
  endtask

  task automatic test_wrap_capture();
    do_reset();
    run_move(1'b0, 5'd0);
    run_move(1'b0, 5'd0);
    run_move(1'b0, 5'd0);
    send_move(1'b1, 5'd6);
    tick();
    checks++;
    if (get_pos(3) !== 5'd0) begin
      errors++;
      $display("FAIL wrap pos3: got %0d required 0", get_pos(3));
    end
    tick();
    checks++;
    if (get_tails(3) !== 3'd2 || get_tails(0) !== 3'd0) begin
      errors++;
      $display("FAIL capture tails: t3=%0d t0=%0d required 2/0", get_tails(3), get_tails(0));
    end
    wait_idle("wrap");
    checks++;
    if (cur_turn !== 2'd3 || win !== 1'b0) begin
      errors++;
      $display("FAIL capture turn: turn=%0d win=%0b required 3/0", cur_turn, win);
    end
  endtask

  task automatic test_multi_capture_win();
    do_reset();
    run_move(1'b1, 5'd12);
    run_move(1'b0, 5'd0);
    run_move(1'b1, 5'd6);
    run_move(1'b0, 5'd0);
    run_move(1'b0, 5'd0);
    checks++;
    if (get_pos(0) !== 5'd12 || get_pos(1) !== 5'd12 || get_pos(2) !== 5'd12 || cur_turn !== 2'd3) begin
      errors++;
      $display("FAIL setup: p0=%0d p1=%0d p2=%0d turn=%0d required 12/12/12/3",
               get_pos(0), get_pos(1), get_pos(2), cur_turn);
    end
    checks++;
    if (get_tails(1) !== 3'd3 || get_tails(0) !== 3'd0 || get_tails(2) !== 3'd0) begin
      errors++;
      $display("FAIL setup tails: t0=%0d t1=%0d t2=%0d required 0/3/0",
               get_tails(0), get_tails(1), get_tails(2));
    end
    run_move(1'b1, 5'd18);
    checks++;
    if (win !== 1'b1 || winner !== 2'd3 || busy !== 1'b1 || get_tails(3) !== 3'd4 || get_pos(3) !== 5'd12) begin
      errors++;
      $display("FAIL win: win=%0b winner=%0d busy=%0b t3=%0d p3=%0d required 1/3/1/4/12",
               win, winner, busy, get_tails(3), get_pos(3));
    end
    send_move(1'b1, 5'd1);
    tick();
    tick();
    checks++;
    if (win !== 1'b1 || busy !== 1'b1 || get_pos(3) !== 5'd12 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL win ignore: win=%0b busy=%0b p3=%0d err=%0b required 1/1/12/0",
               win, busy, get_pos(3), step_err);
    end
    clear_win = 1'b1;
    tick();
    clear_win = 1'b0;
    expect_reset_state("clear_win");
  endtask

  task automatic test_reject();
    do_reset();
    send_move(1'b1, 5'd24);
    checks++;
    if (step_err !== 1'b1 || busy !== 1'b0 || get_pos(0) !== 5'd0 || cur_turn !== 2'd0) begin
      errors++;
      $display("FAIL step_err: err=%0b busy=%0b p0=%0d turn=%0d required 1/0/0/0",
               step_err, busy, get_pos(0), cur_turn);
    end
    tick();
    checks++;
    if (step_err !== 1'b0) begin
      errors++;
      $display("FAIL step_err pulse: got %0b required 0", step_err);
    end
    send_move(1'b0, 5'd0);
    move_req = 1'b1;
    move_hit = 1'b1;
    move_steps = 5'd5;
    tick();
    tick();
    move_req = 1'b0;
    wait_idle("busy_ignore");
    tick();
    tick();
    checks++;
    if (cur_turn !== 2'd1 || get_pos(0) !== 5'd0 || get_pos(1) !== 5'd6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy ignore: turn=%0d p0=%0d p1=%0d busy=%0b required 1/0/6/0",
               cur_turn, get_pos(0), get_pos(1), busy);
    end
    run_move(1'b1, 5'd3);
    send_move(1'b1, 5'd3);
    #2;
    rst = 1'b0;
    #1;
    expect_reset_state("mid_move_reset");
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic check_invariants();
    int sum = 0;
    for (int i = 0; i < 4; i++) sum += int'(get_tails(i));
    checks++;
    if (sum != 4 || $isunknown(tails_flat)) begin
      errors++;
      $display("FAIL tail sum: got %0d required 4", sum);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ($isunknown(get_pos(i)) || get_pos(i) >= 5'd24) begin
        errors++;
        $display("FAIL pos range p%0d: got %0d required <24", i, get_pos(i));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (win === 1'b1) begin
        clear_win = 1'b1;
        tick();
        clear_win = 1'b0;
        check_invariants();
      end else begin
        send_move(1'($urandom_range(0, 1)), 5'($urandom_range(0, 23)));
        check_invariants();
        for (int c = 0; c < 8 && busy === 1'b1 && win !== 1'b1; c++) begin
          tick();
          check_invariants();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_wrap_capture();
    test_multi_capture_win();
    test_reject();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
